// File: rtl/nic_ctrl_csr_shadow.sv
// NIC control CSR block: flat CSR decode into compacted per-port windows,
// shadowed config with idle-deferred commit, discard, saturating drop counters.
module nic_ctrl_csr_shadow #(
  parameter int                  PORT_CNT      = 4,
  parameter logic [PORT_CNT-1:0] PORT_BIT_MASK = 4'b1111,
  parameter int                  D_WIDTH       = 16,
  parameter int                  A_WIDTH       = 10,
  parameter int                  MTU_W         = 16,
  parameter int                  MTU_RST       = 1518,
  parameter logic [15:0]         VER           = 16'h0200
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wr_en_i,
  input  logic                            rd_en_i,
  input  logic [A_WIDTH-1:0]              addr_i,
  input  logic [15:0]                     wr_data_i,
  input  logic [1:0]                      be_i,
  output logic [15:0]                     rd_data_o,
  input  logic [PORT_CNT-1:0]             nic_idle_i,
  input  logic [PORT_CNT-1:0]             drop_pulse_i,
  output logic [PORT_CNT-1:0][47:0]       host_mac_o,
  output logic [PORT_CNT-1:0][47:0]       alt_host_mac_o,
  output logic [PORT_CNT-1:0][11:0]       encaps_vlan_o,
  output logic [PORT_CNT-1:0]             vlan_en_o,
  output logic [PORT_CNT-1:0]             also_use_alt_o,
  output logic [PORT_CNT-1:0]             promisc_o,
  output logic [PORT_CNT-1:0][MTU_W-1:0]  mtu_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_APPLY} cst_t;

  localparam int          SW    = A_WIDTH - 4;
  localparam logic [15:0] MTU_R = 16'(MTU_RST) & 16'h3fff;

  if (D_WIDTH != 16) begin : g_bad_dw
    $error("nic_ctrl_csr_shadow: D_WIDTH must be 16");
  end

  function automatic int slot_of(input int p);
    int n;
    n = 0;
    for (int i = 0; i < p; i++)
      if (PORT_BIT_MASK[i]) n++;
    return n;
  endfunction

  // Implemented bits of each shadow word
  function automatic logic [15:0] rmask(input int r);
    case (r)
      6:       return 16'h8fff;
      7:       return 16'h0003;
      8:       return 16'h3fff;
      default: return 16'hffff;
    endcase
  endfunction

  function automatic logic [15:0] rstv(input int r);
    return (r == 8) ? MTU_R : 16'h0000;
  endfunction

  logic [SW-1:0]              w_slot;
  logic [3:0]                 w_reg;
  logic [15:0]                w_bm;
  logic [PORT_CNT-1:0][15:0]  w_prd;
  logic [15:0]                w_rd_val;
  logic [15:0]                r_rd;

  assign w_slot    = addr_i[A_WIDTH-1:4];
  assign w_reg     = addr_i[3:0];
  assign w_bm      = {{8{be_i[1]}}, {8{be_i[0]}}};
  assign rd_data_o = r_rd;

  always_comb begin
    w_rd_val = '0;
    for (int p = 0; p < PORT_CNT; p++)
      w_rd_val = w_rd_val | w_prd[p];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)        r_rd <= '0;
    else if (rd_en_i) r_rd <= w_rd_val;
  end

  for (genvar p = 0; p < PORT_CNT; p++) begin : g_port
    if (PORT_BIT_MASK[p]) begin : g_en
      localparam int SLOT = slot_of(p);

      cst_t        r_st, w_st_nxt;
      logic [15:0] r_sh  [9];
      logic [15:0] r_act [9];
      logic        r_dirty;
      logic [31:0] r_cnt;
      logic [15:0] r_snap;
      logic        w_sel, w_wr, w_wsh, w_cmd;
      logic        w_commit, w_discard, w_apply, w_pend;
      logic [15:0] w_rv;
      logic        w_unused_act;

      assign w_sel     = (w_slot == SW'(SLOT));
      assign w_wr      = wr_en_i & w_sel;
      assign w_wsh     = w_wr & (w_reg < 4'd9);
      assign w_cmd     = w_wr & (w_reg == 4'd9) & be_i[0];
      assign w_commit  = w_cmd & wr_data_i[0];
      assign w_pend    = (r_st != S_IDLE);
      // Commit wins over discard; discard is dropped while a commit pends
      assign w_discard = w_cmd & wr_data_i[1] & ~wr_data_i[0] & ~w_pend;
      assign w_apply   = (r_st == S_APPLY);

      always_ff @(posedge clk_i) begin
        if (rst_i) r_st <= S_IDLE;
        else       r_st <= w_st_nxt;
      end

      always_comb begin
        w_st_nxt = r_st;
        case (r_st)
          S_IDLE:  if (w_commit)      w_st_nxt = S_WAIT;
          S_WAIT:  if (nic_idle_i[p]) w_st_nxt = S_APPLY;
          S_APPLY: w_st_nxt = S_IDLE;
          default: w_st_nxt = S_IDLE;
        endcase
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < 9; i++) begin
            r_sh[i]  <= rstv(i);
            r_act[i] <= rstv(i);
          end
          r_dirty <= 1'b0;
        end else begin
          for (int i = 0; i < 9; i++) begin
            if (w_apply)   r_act[i] <= r_sh[i];
            if (w_discard) r_sh[i]  <= r_act[i];
            if (w_wsh && w_reg == 4'(i))
              r_sh[i] <= ((r_sh[i] & ~w_bm) | (wr_data_i & w_bm)) & rmask(i);
          end
          if (w_wsh)                      r_dirty <= 1'b1;
          else if (w_apply || w_discard)  r_dirty <= 1'b0;
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_cnt  <= '0;
          r_snap <= '0;
        end else begin
          if (w_wr && w_reg == 4'd12)
            r_cnt <= '0;
          else if (drop_pulse_i[p] && r_cnt != 32'hffff_ffff)
            r_cnt <= r_cnt + 32'd1;
          if (rd_en_i && w_sel && w_reg == 4'd12)
            r_snap <= r_cnt[31:16];
        end
      end

      always_comb begin
        w_rv = '0;
        for (int i = 0; i < 9; i++)
          if (w_reg == 4'(i)) w_rv = r_sh[i];
        case (w_reg)
          4'd10:   w_rv = {14'd0, w_pend, r_dirty};
          4'd11:   w_rv = VER;
          4'd12:   w_rv = r_cnt[15:0];
          4'd13:   w_rv = r_snap;
          default: ;
        endcase
      end

      assign w_prd[p]          = w_sel ? w_rv : 16'h0000;
      assign host_mac_o[p]     = {r_act[2], r_act[1], r_act[0]};
      assign alt_host_mac_o[p] = {r_act[5], r_act[4], r_act[3]};
      assign encaps_vlan_o[p]  = r_act[6][11:0];
      assign vlan_en_o[p]      = r_act[6][15];
      assign also_use_alt_o[p] = r_act[7][1];
      assign promisc_o[p]      = &r_act[7][1:0];
      assign mtu_o[p]          = MTU_W'(r_act[8][13:0]);
      assign w_unused_act      = ^{r_act[6][14:12], r_act[7][15:2],
                                   r_act[8][15:14]};
    end else begin : g_dis
      logic w_unused_in;
      assign w_unused_in       = nic_idle_i[p] | drop_pulse_i[p];
      assign w_prd[p]          = '0;
      assign host_mac_o[p]     = '0;
      assign alt_host_mac_o[p] = '0;
      assign encaps_vlan_o[p]  = '0;
      assign vlan_en_o[p]      = 1'b0;
      assign also_use_alt_o[p] = 1'b0;
      assign promisc_o[p]      = 1'b0;
      assign mtu_o[p]          = '0;
    end
  end

endmodule

// File: tb/tb_nic_ctrl_csr_shadow.sv
// Bench for nic_ctrl_csr_shadow: field-level config model, directed
// commit/discard/counter cases, random CSR traffic, compacted-window instance.
module tb_nic_ctrl_csr_shadow;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic             a_we, a_re, b_we, b_re;
  logic [9:0]       a_addr, b_addr;
  logic [15:0]      a_wd, b_wd, a_rd, b_rd;
  logic [1:0]       a_be, b_be;
  logic [3:0]       a_idle, a_drop, b_idle, b_drop;
  logic [3:0][47:0] a_hm, a_am, b_hm, b_am;
  logic [3:0][11:0] a_vid, b_vid;
  logic [3:0]       a_ven, a_alt, a_pro, b_ven, b_alt, b_pro;
  logic [3:0][15:0] a_mtu, b_mtu;

  nic_ctrl_csr_shadow u_a (
    .clk_i(clk), .rst_i(rst), .wr_en_i(a_we), .rd_en_i(a_re),
    .addr_i(a_addr), .wr_data_i(a_wd), .be_i(a_be), .rd_data_o(a_rd),
    .nic_idle_i(a_idle), .drop_pulse_i(a_drop),
    .host_mac_o(a_hm), .alt_host_mac_o(a_am), .encaps_vlan_o(a_vid),
    .vlan_en_o(a_ven), .also_use_alt_o(a_alt), .promisc_o(a_pro),
    .mtu_o(a_mtu)
  );

  nic_ctrl_csr_shadow #(.PORT_BIT_MASK(4'b1010)) u_b (
    .clk_i(clk), .rst_i(rst), .wr_en_i(b_we), .rd_en_i(b_re),
    .addr_i(b_addr), .wr_data_i(b_wd), .be_i(b_be), .rd_data_o(b_rd),
    .nic_idle_i(b_idle), .drop_pulse_i(b_drop),
    .host_mac_o(b_hm), .alt_host_mac_o(b_am), .encaps_vlan_o(b_vid),
    .vlan_en_o(b_ven), .also_use_alt_o(b_alt), .promisc_o(b_pro),
    .mtu_o(b_mtu)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [47:0] hm;
    logic [47:0] am;
    logic [11:0] vid;
    logic        ven;
    logic [1:0]  mode;
    logic [13:0] mtu;
  } cfg_t;

  cfg_t        m_sh [4];
  cfg_t        m_act[4];
  bit          m_dirty[4];
  bit          m_pend[4];
  logic [31:0] m_cnt[4];
  logic [15:0] m_snap[4];

  function automatic logic [15:0] word(input cfg_t c, input int r);
    case (r)
      0: return c.hm[15:0];
      1: return c.hm[31:16];
      2: return c.hm[47:32];
      3: return c.am[15:0];
      4: return c.am[31:16];
      5: return c.am[47:32];
      6: return {c.ven, 3'b000, c.vid};
      7: return {14'd0, c.mode};
      8: return {2'b00, c.mtu};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic cfg_t put(input cfg_t c, input int r,
                               input logic [15:0] w);
    cfg_t n;
    n = c;
    case (r)
      0: n.hm[15:0]  = w;
      1: n.hm[31:16] = w;
      2: n.hm[47:32] = w;
      3: n.am[15:0]  = w;
      4: n.am[31:16] = w;
      5: n.am[47:32] = w;
      6: begin n.vid = w[11:0]; n.ven = w[15]; end
      7: n.mode = w[1:0];
      8: n.mtu  = w[13:0];
      default: ;
    endcase
    return n;
  endfunction

  task automatic m_reset();
    for (int p = 0; p < 4; p++) begin
      m_sh[p]     = '0;
      m_sh[p].mtu = 14'd1518;
      m_act[p]    = m_sh[p];
      m_dirty[p]  = 0;
      m_pend[p]   = 0;
      m_cnt[p]    = 0;
      m_snap[p]   = 0;
    end
  endtask

  task automatic m_write(input int p, input int r, input logic [15:0] d,
                         input logic [1:0] be);
    logic [15:0] bm, ow;
    bm = {{8{be[1]}}, {8{be[0]}}};
    if (r < 9) begin
      ow = word(m_sh[p], r);
      m_sh[p] = put(m_sh[p], r, (ow & ~bm) | (d & bm));
      m_dirty[p] = 1;
    end else if (r == 9 && be[0]) begin
      if (d[0]) m_pend[p] = 1;
      else if (d[1] && !m_pend[p]) begin
        m_sh[p] = m_act[p];
        m_dirty[p] = 0;
      end
    end else if (r == 12) begin
      m_cnt[p] = 0;
    end
  endtask

  function automatic logic [15:0] m_read(input int p, input int r);
    if (r < 9) return word(m_sh[p], r);
    case (r)
      10: return {14'd0, m_pend[p], m_dirty[p]};
      11: return 16'h0200;
      12: begin
        m_snap[p] = m_cnt[p][31:16];
        return m_cnt[p][15:0];
      end
      13: return m_snap[p];
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_apply(input int p);
    m_act[p] = m_sh[p];
    m_dirty[p] = 0;
    m_pend[p] = 0;
  endtask

  function automatic logic [9:0] ad(input int p, input int r);
    return 10'((p << 4) | r);
  endfunction

  task automatic bus(input bit b, input bit we, input bit re,
                     input logic [9:0] adr, input logic [15:0] d,
                     input logic [1:0] be, output logic [15:0] rd);
    if (b) begin
      b_we = we; b_re = re; b_addr = adr; b_wd = d; b_be = be;
    end else begin
      a_we = we; a_re = re; a_addr = adr; a_wd = d; a_be = be;
    end
    tick();
    rd = b ? b_rd : a_rd;
    a_we = 0; a_re = 0; b_we = 0; b_re = 0;
  endtask

  task automatic a_wr(input int p, input int r, input logic [15:0] d,
                      input logic [1:0] be);
    logic [15:0] x;
    bus(0, 1, 0, ad(p, r), d, be, x);
    m_write(p, r, d, be);
  endtask

  task automatic a_rd_chk(input int p, input int r, input string tag);
    logic [15:0] e, g;
    e = m_read(p, r);
    bus(0, 0, 1, ad(p, r), 16'h0, 2'b00, g);
    chk(tag, g, e);
  endtask

  task automatic a_rw_chk(input int p, input int r, input logic [15:0] d,
                          input logic [1:0] be, input string tag);
    logic [15:0] e, g;
    e = m_read(p, r);
    bus(0, 1, 1, ad(p, r), d, be, g);
    m_write(p, r, d, be);
    chk(tag, g, e);
  endtask

  task automatic chk_out(input int p, input string tag);
    chk({tag, "_hmac"}, a_hm[p], m_act[p].hm);
    chk({tag, "_amac"}, a_am[p], m_act[p].am);
    chk({tag, "_vid"},  a_vid[p], m_act[p].vid);
    chk({tag, "_ven"},  a_ven[p], m_act[p].ven);
    chk({tag, "_alt"},  a_alt[p], m_act[p].mode[1]);
    chk({tag, "_pro"},  a_pro[p], m_act[p].mode == 2'b11);
    chk({tag, "_mtu"},  a_mtu[p], {2'b00, m_act[p].mtu});
  endtask

  task automatic b_wr(input logic [9:0] adr, input logic [15:0] d);
    logic [15:0] x;
    bus(1, 1, 0, adr, d, 2'b11, x);
  endtask

  task automatic b_rd_chk(input logic [9:0] adr, input logic [15:0] e,
                          input string tag);
    logic [15:0] g;
    bus(1, 0, 1, adr, 16'h0, 2'b00, g);
    chk(tag, g, e);
  endtask

  int p, r, op;

  initial begin
    rst = 1;
    a_we = 0; a_re = 0; a_addr = 0; a_wd = 0; a_be = 0;
    b_we = 0; b_re = 0; b_addr = 0; b_wd = 0; b_be = 0;
    a_idle = 4'hf; a_drop = 0; b_idle = 4'hf; b_drop = 0;
    m_reset();
    repeat (3) tick();
    rst = 0;
    tick();

    // reset state
    chk("rst_mtu0", a_mtu[0], 16'd1518);
    chk("rst_hmac0", a_hm[0], 48'h0);
    a_rd_chk(0, 10, "rst_status");
    a_rd_chk(0, 11, "ver");
    chk_out(0, "rst");

    // MAC commit on an idle port, exact 2-cycle latency
    a_wr(0, 0, 16'h5566, 2'b11);
    a_wr(0, 1, 16'h3344, 2'b11);
    a_wr(0, 2, 16'h1122, 2'b11);
    a_rd_chk(0, 10, "dirty_before_commit");
    a_wr(0, 9, 16'h0001, 2'b01);
    chk("commit_e0", a_hm[0], 48'h0);
    tick();
    chk("commit_e1", a_hm[0], 48'h0);
    tick();
    m_apply(0);
    chk("commit_e2", a_hm[0], 48'h1122_3344_5566);
    chk_out(0, "commit");
    a_rd_chk(0, 10, "status_after_commit");

    // commit deferred until the NIC goes idle
    a_idle[1] = 1'b0;
    a_wr(1, 8, 16'd9000, 2'b11);
    a_wr(1, 9, 16'h0001, 2'b01);
    repeat (25) tick();
    a_wr(1, 9, 16'h0001, 2'b01);
    a_wr(1, 9, 16'h0002, 2'b01);
    repeat (25) tick();
    chk("wait_mtu1", a_mtu[1], 16'd1518);
    a_rd_chk(1, 10, "wait_status");
    a_rd_chk(1, 8, "wait_shadow_mtu");
    a_idle[1] = 1'b1;
    tick();
    chk("idle_e1_mtu1", a_mtu[1], 16'd1518);
    tick();
    m_apply(1);
    chk("idle_e2_mtu1", a_mtu[1], 16'd9000);
    a_rd_chk(1, 10, "status_after_wait");

    // discard restores the active value
    a_wr(2, 7, 16'h0003, 2'b11);
    a_wr(2, 9, 16'h0002, 2'b01);
    a_rd_chk(2, 7, "discard_main");
    chk("discard_promisc", a_pro[2], 1'b0);
    a_rd_chk(2, 10, "discard_status");

    // read-during-write and byte lanes
    a_rw_chk(0, 3, 16'h1234, 2'b11, "rw_prewrite");
    a_rd_chk(0, 3, "rw_after");
    a_wr(0, 4, 16'habcd, 2'b10);
    a_rd_chk(0, 4, "be_hi_only");
    a_wr(0, 6, 16'hffff, 2'b11);
    a_rd_chk(0, 6, "vlan_mask");
    chk("slot4_rd", 0, 0 + 0);
    begin
      logic [15:0] g;
      bus(0, 1, 0, 10'h040, 16'hffff, 2'b11, g);
      bus(0, 0, 1, 10'h040, 16'h0, 2'b00, g);
      chk("slot_oob_rd", g, 16'h0000);
      bus(0, 0, 1, ad(0, 14), 16'h0, 2'b00, g);
      chk("reg14_rd", g, 16'h0000);
    end

    // drop counter across the 16-bit boundary
    a_drop[3] = 1'b1;
    repeat (65538) tick();
    m_cnt[3] = 32'd65538;
    a_rd_chk(3, 12, "drop_lo_pulse");
    m_cnt[3] = m_cnt[3] + 1;
    a_drop[3] = 1'b0;
    a_rd_chk(3, 13, "drop_hi_snap");
    a_drop[3] = 1'b1;
    a_wr(3, 12, 16'h0000, 2'b11);
    a_drop[3] = 1'b0;
    a_rd_chk(3, 13, "snap_kept_on_clear");
    a_rd_chk(3, 12, "drop_cleared");

    // random CSR traffic against the model
    for (int it = 0; it < 80; it++) begin
      p  = $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      if (op < 6) begin
        a_wr(p, $urandom_range(0, 8), 16'($urandom), 2'($urandom));
      end else if (op < 8) begin
        a_wr(p, 9, 16'($urandom_range(1, 3)), 2'b01);
        if (m_pend[p]) begin
          tick();
          tick();
          m_apply(p);
        end
        chk_out(p, "rnd_out");
      end else begin
        a_wr(p, 9, 16'h0002, 2'b01);
      end
      r = $urandom_range(0, 15);
      a_rd_chk(p, r, "rnd_rd");
    end

    // reset while a commit waits
    a_idle[1] = 1'b0;
    a_wr(1, 8, 16'd500, 2'b11);
    a_wr(1, 9, 16'h0001, 2'b01);
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0;
    m_reset();
    a_idle = 4'hf;
    repeat (3) tick();
    chk_out(1, "rst_abort");
    a_rd_chk(1, 10, "rst_abort_status");
    a_rd_chk(1, 8, "rst_abort_shadow");

    // compacted windows with mask 1010
    chk("b_rst_mtu1", b_mtu[1], 16'd1518);
    chk("b_rst_mtu0", b_mtu[0], 16'd0);
    b_wr(10'h000, 16'haaaa);
    b_wr(10'h001, 16'hbbbb);
    b_wr(10'h009, 16'h0001);
    repeat (2) tick();
    chk("b_slot0_hmac1", b_hm[1], 48'h0000_bbbb_aaaa);
    b_wr(10'h018, 16'd100);
    b_wr(10'h019, 16'h0001);
    repeat (2) tick();
    chk("b_slot1_mtu3", b_mtu[3], 16'd100);
    chk("b_mtu1_kept", b_mtu[1], 16'd1518);
    b_rd_chk(10'h020, 16'h0000, "b_slot2_rd");
    b_wr(10'h020, 16'hffff);
    b_rd_chk(10'h020, 16'h0000, "b_slot2_wr_ignored");
    b_rd_chk(10'h00b, 16'h0200, "b_slot0_ver");
    b_rd_chk(10'h010, 16'h0000, "b_slot1_w0");
    chk("b_hmac0", b_hm[0], 48'h0);
    chk("b_hmac2", b_hm[2], 48'h0);
    chk("b_mtu0", b_mtu[0], 16'd0);
    chk("b_mtu2", b_mtu[2], 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
